// File: rtl/dbg_responder_if.sv
// Debug read link between dbg_responder and the RF / data-memory read port.
// The master raises rd_req with a stable target and address.
// The slave answers with a one-cycle rd_ack strobe carrying rd_data.
interface dbg_responder_if #(
    parameter int ADDR_W = 8
);
    logic              rd_req;
    logic              rd_mem;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [31:0]       rd_data;

    modport master (
        output rd_req,
        output rd_mem,
        output rd_addr,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_mem,
        input  rd_addr,
        output rd_ack,
        output rd_data
    );
endinterface

// File: rtl/dbg_responder.sv
// CPU-side end of the debug-unit link.
// Synchronises the operator buttons and generates CPU run control.
// Keeps the shared debug address counter.
// Runs auto-refreshing RF/memory reads over the req/ack link.
// Muxes CPU probes into the registered display word and the LED bus.
module dbg_responder #(
    parameter int ADDR_W  = 8,
    parameter int SYNC_N  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   succ,
    input  logic                   step,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   m_rf,
    input  logic [2:0]             sel,
    input  logic [31:0]            probe_pc1,
    input  logic [31:0]            probe_pc,
    input  logic [31:0]            probe_instr,
    input  logic [31:0]            probe_alu_a,
    input  logic [31:0]            probe_wdata,
    input  logic [31:0]            probe_alu_result,
    input  logic [31:0]            probe_read_data,
    input  logic [11:0]            ctrl,
    dbg_responder_if.master        rd_bus,
    output logic                   cpu_en,
    output logic [31:0]            disp_data,
    output logic [11:0]            led
);

    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0] TMO_WORD = 32'hDEAD_BEEF;
    localparam int          LW       = (ADDR_W < 8) ? ADDR_W : 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAP
    } state_t;

    state_t state;
    state_t state_nx;

    // Button bit order inside the synchroniser: {dec, inc, step}
    logic [2:0]        btn_sync [SYNC_N];
    logic [2:0]        btn_prev;
    logic [2:0]        btn_pulse;
    logic              step_pulse;
    logic              inc_pulse;
    logic              dec_pulse;

    logic [ADDR_W-1:0] addr;
    logic [7:0]        addr_led;

    logic              latch_req;
    logic              cap_take;
    logic              cap_tmo;
    logic [TW-1:0]     tmo_cnt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_mem_q;
    logic              discard;
    logic [31:0]       cap_data;
    logic              cap_err;
    logic              err;
    logic [31:0]       probe_word;

    assign btn_pulse  = btn_sync[SYNC_N-1] & ~btn_prev;
    assign step_pulse = btn_pulse[0];
    assign inc_pulse  = btn_pulse[1];
    assign dec_pulse  = btn_pulse[2];

    // Button synchroniser chain plus previous-level flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_N; i++) begin
                btn_sync[i] <= '0;
            end
            btn_prev <= '0;
        end else begin
            btn_sync[0] <= {dec, inc, step};
            for (int unsigned i = 1; i < SYNC_N; i++) begin
                btn_sync[i] <= btn_sync[i-1];
            end
            btn_prev <= btn_sync[SYNC_N-1];
        end
    end

    // CPU clock enable: free-running in continuous mode, one cycle per step otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_en <= 1'b0;
        end else begin
            cpu_en <= succ | step_pulse;
        end
    end

    // Shared debug address counter; simultaneous inc and dec cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (inc_pulse ^ dec_pulse) begin
            addr <= inc_pulse ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Read FSM next state and datapath strobes
    always_comb begin
        state_nx  = state;
        latch_req = 1'b0;
        cap_take  = 1'b0;
        cap_tmo   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel == 3'd0) begin
                    state_nx  = ST_REQ;
                    latch_req = 1'b1;
                end
            end
            ST_REQ: begin
                if (rd_bus.rd_ack) begin
                    state_nx = ST_CAP;
                    cap_take = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx = ST_CAP;
                    cap_take = 1'b1;
                    cap_tmo  = 1'b1;
                end
            end
            ST_CAP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Request latching, timeout counting and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q <= '0;
            rd_mem_q  <= 1'b0;
            tmo_cnt   <= '0;
            discard   <= 1'b0;
            cap_data  <= '0;
            cap_err   <= 1'b0;
        end else begin
            if (latch_req) begin
                rd_addr_q <= addr;
                rd_mem_q  <= m_rf;
                tmo_cnt   <= '0;
                discard   <= 1'b0;
            end else if (state == ST_REQ) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                // Leaving sel=0 at any point of the request spoils its result
                if (sel != 3'd0) begin
                    discard <= 1'b1;
                end
            end
            if (cap_take) begin
                cap_data <= cap_tmo ? TMO_WORD : rd_bus.rd_data;
                cap_err  <= cap_tmo;
            end
        end
    end

    assign rd_bus.rd_req  = (state == ST_REQ);
    assign rd_bus.rd_addr = rd_addr_q;
    assign rd_bus.rd_mem  = rd_mem_q;

    // Probe selection in sel order 1..7
    always_comb begin
        probe_word = '0;
        case (sel)
            3'd1:    probe_word = probe_pc1;
            3'd2:    probe_word = probe_pc;
            3'd3:    probe_word = probe_instr;
            3'd4:    probe_word = probe_alu_a;
            3'd5:    probe_word = probe_wdata;
            3'd6:    probe_word = probe_alu_result;
            3'd7:    probe_word = probe_read_data;
            default: probe_word = '0;
        endcase
    end

    // Display word: live probe when selected, else the last captured read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data <= '0;
            err       <= 1'b0;
        end else if (sel != 3'd0) begin
            disp_data <= probe_word;
        end else if ((state == ST_CAP) && !discard) begin
            disp_data <= cap_data;
            err       <= cap_err;
        end
    end

    // Low address byte for the LED field, zero-extended for narrow counters
    always_comb begin
        addr_led         = '0;
        addr_led[LW-1:0] = addr[LW-1:0];
    end

    // LED bus: read status and address in read mode, control bundle otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else if (sel == 3'd0) begin
            led <= {err, m_rf, 2'b00, addr_led};
        end else begin
            led <= ctrl;
        end
    end

endmodule

// File: tb/tb_dbg_responder.sv
// Directed self-checking bench for dbg_responder.
module tb_dbg_responder;

    localparam int ADDR_W  = 8;
    localparam int SYNC_N  = 2;
    localparam int TIMEOUT = 15;

    localparam logic [31:0] P_PC1  = 32'h1111_0001;
    localparam logic [31:0] P_PC   = 32'h2222_0002;
    localparam logic [31:0] P_INS  = 32'h0000_0013;
    localparam logic [31:0] P_ALA  = 32'h4444_0004;
    localparam logic [31:0] P_WD   = 32'h5555_0005;
    localparam logic [31:0] P_ALR  = 32'h6666_0006;
    localparam logic [31:0] P_RD   = 32'h7777_0007;
    localparam logic [11:0] CTRL_V = 12'hA5C;

    logic        clk = 1'b0;
    logic        rst;
    logic        succ;
    logic        step;
    logic        inc;
    logic        dec;
    logic        m_rf;
    logic [2:0]  sel;
    logic [31:0] probe_pc1;
    logic [31:0] probe_pc;
    logic [31:0] probe_instr;
    logic [31:0] probe_alu_a;
    logic [31:0] probe_wdata;
    logic [31:0] probe_alu_result;
    logic [31:0] probe_read_data;
    logic [11:0] ctrl;
    logic        cpu_en;
    logic [31:0] disp_data;
    logic [11:0] led;

    int total = 0;
    int bad   = 0;

    dbg_responder_if #(.ADDR_W(ADDR_W)) rd_bus ();

    dbg_responder #(
        .ADDR_W (ADDR_W),
        .SYNC_N (SYNC_N),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .succ            (succ),
        .step            (step),
        .inc             (inc),
        .dec             (dec),
        .m_rf            (m_rf),
        .sel             (sel),
        .probe_pc1       (probe_pc1),
        .probe_pc        (probe_pc),
        .probe_instr     (probe_instr),
        .probe_alu_a     (probe_alu_a),
        .probe_wdata     (probe_wdata),
        .probe_alu_result(probe_alu_result),
        .probe_read_data (probe_read_data),
        .ctrl            (ctrl),
        .rd_bus          (rd_bus),
        .cpu_en          (cpu_en),
        .disp_data       (disp_data),
        .led             (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic lvl);
        int n = 0;
        while (rd_bus.rd_req !== lvl && n < 40) begin
            tick();
            n++;
        end
        check("wait_req", 32'(rd_bus.rd_req), 32'(lvl));
    endtask

    task automatic press(input logic i, input logic d);
        inc = i;
        dec = d;
        repeat (4) tick();
        inc = 1'b0;
        dec = 1'b0;
        repeat (3) tick();
    endtask

    task automatic read_ack(input int dly, input logic [31:0] data, input logic [7:0] exp_addr,
                            input logic exp_mem, input logic flip, input logic [11:0] exp_led);
        wait_req(1'b0);
        wait_req(1'b1);
        check("rd_addr", 32'(rd_bus.rd_addr), 32'(exp_addr));
        check("rd_mem", 32'(rd_bus.rd_mem), 32'(exp_mem));
        if (flip) m_rf = ~m_rf;
        repeat (dly) tick();
        check("rd_addr_hold", 32'(rd_bus.rd_addr), 32'(exp_addr));
        check("rd_mem_hold", 32'(rd_bus.rd_mem), 32'(exp_mem));
        rd_bus.rd_ack  = 1'b1;
        rd_bus.rd_data = data;
        tick();
        rd_bus.rd_ack  = 1'b0;
        rd_bus.rd_data = '0;
        check("rd_req_cap", 32'(rd_bus.rd_req), 32'd0);
        tick();
        check("rd_disp", disp_data, data);
        tick();
        check("rd_led", 32'(led), 32'(exp_led));
    endtask

    initial begin
        int pulses;
        int pos;
        int n;

        rst = 1'b1; succ = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0;
        m_rf = 1'b0; sel = 3'd1; ctrl = CTRL_V;
        probe_pc1 = P_PC1; probe_pc = P_PC; probe_instr = P_INS; probe_alu_a = P_ALA;
        probe_wdata = P_WD; probe_alu_result = P_ALR; probe_read_data = P_RD;
        rd_bus.rd_ack = 1'b0; rd_bus.rd_data = '0;

        #12;
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_rd_req", 32'(rd_bus.rd_req), 32'd0);
        check("rst_rd_addr", 32'(rd_bus.rd_addr), 32'd0);
        check("rst_rd_mem", 32'(rd_bus.rd_mem), 32'd0);
        check("rst_disp", disp_data, 32'd0);
        check("rst_led", 32'(led), 32'd0);

        // Continuous run from the first cycle after reset
        tick();
        rst = 1'b0;
        succ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("run_cpu_en", 32'(cpu_en), 32'd1);
        end
        check("probe_pc1", disp_data, P_PC1);
        check("led_ctrl", 32'(led), 32'(CTRL_V));

        // Probe path
        sel = 3'd3;
        tick();
        check("probe_instr", disp_data, P_INS);
        check("probe_rd_req", 32'(rd_bus.rd_req), 32'd0);
        check("probe_led", 32'(led), 32'(CTRL_V));
        sel = 3'd6;
        tick();
        check("probe_alu_res", disp_data, P_ALR);

        // Stray ack outside a request
        rd_bus.rd_ack = 1'b1;
        rd_bus.rd_data = 32'h5555_AAAA;
        tick();
        rd_bus.rd_ack = 1'b0;
        rd_bus.rd_data = '0;
        check("stray_ack_disp", disp_data, P_ALR);
        check("stray_ack_req", 32'(rd_bus.rd_req), 32'd0);

        // Single-step mode
        succ = 1'b0;
        tick();
        check("succ_drop", 32'(cpu_en), 32'd0);
        pulses = 0;
        pos = 0;
        step = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (cpu_en) begin
                pulses++;
                pos = i;
            end
        end
        step = 1'b0;
        check("step_pulses", 32'(pulses), 32'd1);
        check("step_pos", 32'(pos), 32'(SYNC_N + 1));

        // Memory read at address 1
        sel = 3'd1;
        press(1'b1, 1'b0);
        m_rf = 1'b1;
        sel = 3'd0;
        read_ack(2, 32'h1234_5678, 8'h01, 1'b1, 1'b0, 12'h401);

        // Timeout path
        wait_req(1'b0);
        wait_req(1'b1);
        n = 0;
        while (rd_bus.rd_req && n < 40) begin
            n++;
            tick();
        end
        check("tmo_cycles", 32'(n), 32'(TIMEOUT));
        tick();
        check("tmo_disp", disp_data, 32'hDEAD_BEEF);
        tick();
        check("tmo_led", 32'(led), 32'hC01);

        // Next acked read clears the error flag
        read_ack(0, 32'hCAFE_F00D, 8'h01, 1'b1, 1'b0, 12'h401);

        // Address counter wrap and cancellation
        press(1'b0, 1'b1);
        check("addr_dec_0", 32'(led[7:0]), 32'h00);
        press(1'b0, 1'b1);
        check("addr_wrap_ff", 32'(led[7:0]), 32'hFF);
        press(1'b1, 1'b0);
        check("addr_wrap_00", 32'(led[7:0]), 32'h00);
        press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        check("addr_incdec", 32'(led[7:0]), 32'hFF);

        // RF read at 0xFF with m_rf toggled mid-request
        m_rf = 1'b0;
        read_ack(1, 32'h0BAD_F00D, 8'hFF, 1'b0, 1'b1, 12'h4FF);

        // sel leaves 0 during a request: its data must not reach the display
        wait_req(1'b0);
        wait_req(1'b1);
        sel = 3'd2;
        tick();
        sel = 3'd0;
        rd_bus.rd_ack = 1'b1;
        rd_bus.rd_data = 32'h7777_7777;
        tick();
        rd_bus.rd_ack = 1'b0;
        rd_bus.rd_data = '0;
        tick();
        check("discard_disp", disp_data, P_PC);

        // Asynchronous reset mid-run
        sel = 3'd7;
        tick();
        check("probe_read_data", disp_data, P_RD);
        #2;
        rst = 1'b1;
        #1;
        check("arst_disp", disp_data, 32'd0);
        check("arst_led", 32'(led), 32'd0);
        check("arst_cpu_en", 32'(cpu_en), 32'd0);
        check("arst_rd_req", 32'(rd_bus.rd_req), 32'd0);
        check("arst_rd_addr", 32'(rd_bus.rd_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
